// File: rtl/serv_mem_arb.sv
// Arbitrates the SERV ibus/dbus Wishbone-classic masters onto one single-port
// synchronous SRAM (1-cycle read latency). One transaction in flight, dbus wins.
module serv_mem_arb #(
  parameter int MEM_AW        = 12,
  parameter bit MEM_INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_ibus_adr,
  input  logic              i_ibus_cyc,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic [31:0]       i_dbus_adr,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  input  logic              i_dbus_we,
  input  logic              i_dbus_cyc,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [2:0] {IDLE, IRD, DRD, WACK, RACK} state_e;

  state_e      state_q, state_d;
  logic        ibus_ack_q, ibus_ack_d;
  logic        dbus_ack_q, dbus_ack_d;
  logic [31:0] ibus_rdt_q, ibus_rdt_d;
  logic [31:0] dbus_rdt_q, dbus_rdt_d;

  // Address bits outside the SRAM word window are deliberately ignored (wrap).
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_ibus_adr[31:MEM_AW+2], i_ibus_adr[1:0],
                             i_dbus_adr[31:MEM_AW+2], i_dbus_adr[1:0]};

  assign o_mem_wdata = i_dbus_dat;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    ibus_ack_d = 1'b0;
    dbus_ack_d = 1'b0;
    ibus_rdt_d = ibus_rdt_q;
    dbus_rdt_d = dbus_rdt_q;
    o_mem_en   = 1'b0;
    o_mem_we   = 4'b0000;
    o_mem_addr = i_dbus_adr[MEM_AW+1:2];

    unique case (state_q)
      IDLE: begin
        if (i_dbus_cyc) begin
          o_mem_en   = 1'b1;
          o_mem_addr = i_dbus_adr[MEM_AW+1:2];
          o_mem_we   = i_dbus_we ? i_dbus_sel : 4'b0000;
          state_d    = i_dbus_we ? WACK : DRD;
        end else if (i_ibus_cyc) begin
          o_mem_en   = 1'b1;
          o_mem_addr = i_ibus_adr[MEM_AW+1:2];
          state_d    = IRD;
        end
      end
      IRD: begin
        ibus_rdt_d = i_mem_rdata;
        ibus_ack_d = 1'b1;
        state_d    = RACK;
      end
      DRD: begin
        dbus_rdt_d = i_mem_rdata;
        dbus_ack_d = 1'b1;
        state_d    = RACK;
      end
      WACK: begin
        dbus_ack_d = 1'b1;
        state_d    = RACK;
      end
      // The master still holds cyc during its ack cycle; ignoring requests here
      // is what prevents a duplicate accept.
      RACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ibus_ack_q <= ibus_ack_d;
      dbus_ack_q <= dbus_ack_d;
    end
  end

  // NOTE: read-data registers are pure datapath and only need a reset when a defined
  // post-reset value is wanted; leaving them unreset allows reset-less flops.
  if (MEM_INIT_ZERO) begin : g_rdt_rst
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ibus_rdt_q <= '0;
        dbus_rdt_q <= '0;
      end else begin
        ibus_rdt_q <= ibus_rdt_d;
        dbus_rdt_q <= dbus_rdt_d;
      end
    end
  end else begin : g_rdt_norst
    always_ff @(posedge clk) begin
      ibus_rdt_q <= ibus_rdt_d;
      dbus_rdt_q <= dbus_rdt_d;
    end
  end

  assign o_ibus_ack = ibus_ack_q;
  assign o_dbus_ack = dbus_ack_q;
  assign o_ibus_rdt = ibus_rdt_q;
  assign o_dbus_rdt = dbus_rdt_q;

endmodule

// File: tb/tb_serv_mem_arb.sv
// Directed and random bench for serv_mem_arb: SRAM model, reference memory and
// an expected-ack scoreboard filled at accept time and drained on each ack.
module tb_serv_mem_arb;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       ibus_adr, dbus_adr, dbus_dat;
  logic              ibus_cyc, dbus_cyc, dbus_we;
  logic [3:0]        dbus_sel;
  logic [31:0]       ibus_rdt, dbus_rdt;
  logic              ibus_ack, dbus_ack;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  serv_mem_arb #(.MEM_AW(MEM_AW), .MEM_INIT_ZERO(1'b1)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (ibus_rdt),
    .o_ibus_ack (ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (dbus_rdt),
    .o_dbus_ack (dbus_ack),
    .o_mem_addr (mem_addr),
    .o_mem_en   (mem_en),
    .o_mem_we   (mem_we),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int cyc_n  = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [31:0] data;
    int          t;
  } exp_t;
  exp_t sb_q[$];

  // SRAM model: read data only meaningful the cycle after a read strobe.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_i(input logic [31:0] adr);
    ibus_adr = adr;
    ibus_cyc = 1'b1;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    dbus_we  = we;
    dbus_adr = adr;
    dbus_sel = sel;
    dbus_dat = dat;
    dbus_cyc = 1'b1;
  endtask

  // Called just after a negedge in the cycle the DUT must accept a request.
  task automatic accept(input string tag, input bit is_d, input logic we,
                        input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] wdat);
    logic [MEM_AW-1:0] wa;
    exp_t e;
    wa = adr[MEM_AW+1:2];
    check({tag, "_en"}, {31'd0, mem_en}, 32'd1);
    check({tag, "_addr"}, {20'd0, mem_addr}, {20'd0, wa});
    check({tag, "_we"}, {28'd0, mem_we}, {28'd0, (is_d && we) ? sel : 4'b0000});
    check({tag, "_no_ack"}, {30'd0, ibus_ack, dbus_ack}, 32'd0);
    if (is_d && we) check({tag, "_wdata"}, mem_wdata, wdat);
    e.is_d  = is_d;
    e.is_wr = is_d && we;
    e.data  = ref_mem[wa];
    e.t     = cyc_n;
    if (e.is_wr)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[wa][8*b +: 8] = wdat[8*b +: 8];
    sb_q.push_back(e);
  endtask

  // Waits for the next ack, popping and checking the oldest expectation;
  // the acked master drops cyc during its ack cycle.
  task automatic wait_ack(input string tag, input int budget);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk); #1;
      check({tag, "_en_busy"}, {31'd0, mem_en}, 32'd0);
      if (ibus_ack || dbus_ack) begin
        got = 1'b1;
        check({tag, "_one_ack"}, {31'd0, ibus_ack & dbus_ack}, 32'd0);
        if (sb_q.size() == 0) begin
          check({tag, "_spurious_ack"}, sb_q.size(), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_bus"}, {31'd0, dbus_ack}, {31'd0, e.is_d});
          check({tag, "_latency"}, cyc_n - e.t, 32'd2);
          if (!e.is_wr) check({tag, "_rdt"}, e.is_d ? dbus_rdt : ibus_rdt, e.data);
        end
        if (dbus_ack) dbus_cyc = 1'b0;
        else          ibus_cyc = 1'b0;
      end
    end
    if (!got) check({tag, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, dat;
    bit          want_i, want_d, we;
    logic [3:0]  sel;

    rst_n    = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      sram[i]    = ref_mem[i];
    end
    ref_mem[4] = 32'h0000_0013;
    sram[4]    = 32'h0000_0013;

    repeat (2) @(negedge clk);
    #1;
    check("rst_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    check("rst_ibus_rdt", ibus_rdt, 32'd0);
    check("rst_dbus_rdt", dbus_rdt, 32'd0);
    check("rst_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a fetch abandons it without an ack.
    @(negedge clk); drive_i(32'h10);
    @(negedge clk); ibus_cyc = 1'b0; rst_n = 1'b0; #1;
    check("midrst_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("midrst_noack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    end

    @(negedge clk); drive_i(32'h10); #1;
    accept("fetch", 1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
    wait_ack("fetch", 4);
    check("fetch_rdt", ibus_rdt, 32'h0000_0013);
    @(negedge clk); #1;
    check("fetch_ack_pulse", {31'd0, ibus_ack}, 32'd0);

    @(negedge clk); drive_d(1'b1, 32'h21, 4'b0010, 32'hAABB_CCDD); #1;
    accept("bwr", 1'b1, 1'b1, 32'h21, 4'b0010, 32'hAABB_CCDD);
    wait_ack("bwr", 4);
    check("ibus_rdt_hold", ibus_rdt, 32'h0000_0013);
    @(negedge clk); drive_d(1'b0, 32'h20, 4'h0, 32'h0); #1;
    accept("bwr_rb", 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    wait_ack("bwr_rb", 4);

    // Both buses request in the same IDLE cycle: dbus first, ibus at N+3.
    @(negedge clk); drive_i(32'h0C); drive_d(1'b0, 32'h40, 4'h0, 32'h0); #1;
    accept("sim_d", 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
    wait_ack("sim_d", 4);
    @(negedge clk); #1;
    accept("sim_i", 1'b0, 1'b0, 32'h0C, 4'h0, 32'h0);
    wait_ack("sim_i", 4);

    @(negedge clk); drive_d(1'b0, 32'h0000_4008, 4'h0, 32'h0); #1;
    check("wrap_addr", {20'd0, mem_addr}, 32'd2);
    accept("wrap_hi", 1'b1, 1'b0, 32'h0000_4008, 4'h0, 32'h0);
    wait_ack("wrap_hi", 4);
    @(negedge clk); drive_d(1'b0, 32'h8, 4'h0, 32'h0); #1;
    accept("wrap_lo", 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    wait_ack("wrap_lo", 4);

    // sel=0 write, with an ibus request held from the accept cycle onward.
    @(negedge clk); drive_d(1'b1, 32'h30, 4'b0000, 32'hFFFF_FFFF); drive_i(32'h30); #1;
    accept("sel0", 1'b1, 1'b1, 32'h30, 4'b0000, 32'hFFFF_FFFF);
    wait_ack("sel0", 4);
    @(negedge clk); #1;
    accept("held_i", 1'b0, 1'b0, 32'h30, 4'h0, 32'h0);
    wait_ack("held_i", 4);

    // Master abandons cyc right after acceptance; the write still lands and acks.
    @(negedge clk); drive_d(1'b1, 32'h50, 4'hF, 32'h1234_5678); #1;
    accept("drop", 1'b1, 1'b1, 32'h50, 4'hF, 32'h1234_5678);
    @(negedge clk); dbus_cyc = 1'b0; #1;
    check("drop_en_busy", {31'd0, mem_en}, 32'd0);
    wait_ack("drop", 3);
    @(negedge clk); drive_i(32'h50); #1;
    accept("drop_rb", 1'b0, 1'b0, 32'h50, 4'h0, 32'h0);
    wait_ack("drop_rb", 4);

    repeat (60) begin
      @(negedge clk);
      want_i = 1'($urandom_range(0, 1));
      want_d = 1'($urandom_range(0, 1));
      if (!want_i && !want_d) want_i = 1'b1;
      adr = $urandom & 32'hFFFF_C03F;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      dat = $urandom;
      if (want_d) drive_d(we, adr, sel, dat);
      if (want_i) drive_i($urandom & 32'hFFFF_C03F);
      #1;
      if (want_d) begin
        accept("rnd_d", 1'b1, we, adr, sel, dat);
        wait_ack("rnd_d", 4);
        if (want_i) begin @(negedge clk); #1; end
      end
      if (want_i) begin
        accept("rnd_i", 1'b0, 1'b0, ibus_adr, 4'h0, 32'h0);
        wait_ack("rnd_i", 4);
      end
    end

    @(negedge clk); #1;
    check("sb_drained", sb_q.size(), 32'd0);
    check("final_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      check("final_idle", {29'd0, ibus_ack, dbus_ack, mem_en}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
